// File: rtl/mem_master.sv
// mem_master: valid/ready bus initiator that sequences the single-port RAM's strobes.
// Define MEM_MASTER_WRITE_VERIFY_EN to add a read-back check after every write.
module mem_master #(
    parameter int A = 8,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [A-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    input  logic         clear_req,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         mem_enable,
    output logic         mem_clear,
    output logic         mem_read_en,
    output logic         mem_write_en,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_datain,
    input  logic [W-1:0] mem_dataout
);

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_CAP, WR_CMD, VFY_CMD, VFY_CAP, CLR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_CAP, WR_CMD, CLR
    } state_t;
`endif

    state_t         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic           mem_enable_q, mem_enable_d;
    logic           mem_clear_q, mem_clear_d;
    logic           mem_read_en_q, mem_read_en_d;
    logic           mem_write_en_q, mem_write_en_d;
    logic [A-1:0]   mem_addr_q, mem_addr_d;
    logic [W-1:0]   mem_datain_q, mem_datain_d;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    logic           rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        mem_enable_d   = 1'b1;
        mem_clear_d    = 1'b1;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_datain_d   = mem_datain_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        rsp_err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Ready rises on the first edge after reset; clear outranks a pending request.
                req_ready_d = 1'b1;
                if (req_ready_q && clear_req) begin
                    state_d     = CLR;
                    mem_clear_d = 1'b0;
                    req_ready_d = 1'b0;
                end else if (req_ready_q && req_valid) begin
                    mem_addr_d   = req_addr;
                    mem_datain_d = req_wdata;
                    req_ready_d  = 1'b0;
                    if (req_write) begin
                        state_d        = WR_CMD;
                        mem_write_en_d = 1'b1;
                    end else begin
                        state_d       = RD_CMD;
                        mem_read_en_d = 1'b1;
                    end
                end
            end
            RD_CMD: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                state_d     = IDLE;
                rsp_rdata_d = mem_dataout;
                rsp_valid_d = 1'b1;
                req_ready_d = 1'b1;
            end
            WR_CMD: begin
`ifdef MEM_MASTER_WRITE_VERIFY_EN
                state_d       = VFY_CMD;
                mem_read_en_d = 1'b1;
`else
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                req_ready_d = 1'b1;
`endif
            end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            VFY_CMD: begin
                state_d = VFY_CAP;
            end
            VFY_CAP: begin
                state_d     = IDLE;
                rsp_rdata_d = mem_dataout;
                rsp_err_d   = (mem_dataout != mem_datain_q);
                rsp_valid_d = 1'b1;
                req_ready_d = 1'b1;
            end
`endif
            CLR: begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            mem_enable_q   <= 1'b0;
            mem_clear_q    <= 1'b1;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_datain_q   <= '0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            mem_enable_q   <= mem_enable_d;
            mem_clear_q    <= mem_clear_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_datain_q   <= mem_datain_d;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            rsp_err_q      <= rsp_err_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_enable   = mem_enable_q;
    assign mem_clear    = mem_clear_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_datain   = mem_datain_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: a behavioural RAM on the memory side and a
// transaction-level memory model that predicts every response.
module tb_mem_master;

    localparam int KIND_RD  = 0;
    localparam int KIND_WR  = 1;
    localparam int KIND_CLR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        clear_req;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_enable;
    logic        mem_clear;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;

    int vectors = 0;
    int miscompares = 0;
    int rsp_count = 0;
    int wr_pulse_count = 0;
    int overlap_count = 0;
    int ops_done = 0;

    logic [15:0] ram [256];
    logic [15:0] ram_dout = 16'h0;
    logic        force_en = 1'b0;
    logic [15:0] force_val = 16'h0;

    logic [15:0] ref_mem [256];
    logic [15:0] exp_rdata = 16'h0;
    longint      last_accept = 0;

    mem_master #(.A(8), .W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .clear_req    (clear_req),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_enable   (mem_enable),
        .mem_clear    (mem_clear),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_dataout  (mem_dataout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read and active-low clear.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (!mem_clear) begin
                for (int i = 0; i < 256; i++) ram[i] <= 16'h0;
            end else if (mem_write_en) begin
                ram[mem_addr] <= mem_datain;
            end else if (mem_read_en) begin
                ram_dout <= ram[mem_addr];
            end
        end
    end

    assign mem_dataout = force_en ? force_val : ram_dout;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (rsp_valid) rsp_count++;
        if (mem_write_en) wr_pulse_count++;
        if (mem_read_en && mem_write_en) overlap_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        checkOutput({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({pfx, "_rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
        checkOutput({pfx, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        checkOutput({pfx, "_mem_enable"}, {31'd0, mem_enable}, 32'd0);
        checkOutput({pfx, "_mem_clear"}, {31'd0, mem_clear}, 32'd1);
        checkOutput({pfx, "_read_en"}, {31'd0, mem_read_en}, 32'd0);
        checkOutput({pfx, "_write_en"}, {31'd0, mem_write_en}, 32'd0);
        checkOutput({pfx, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        checkOutput({pfx, "_mem_datain"}, {16'd0, mem_datain}, 32'd0);
    endtask

    // Issue one transaction from a negedge, predict its response, return on the response negedge.
    task automatic applyStimulus(input int kind, input logic [7:0] addr, input logic [15:0] data);
        int guard;
        int lat;
        int exp_lat;
        logic [15:0] readback;
        logic        exp_err;
        req_valid = (kind != KIND_CLR);
        clear_req = (kind == KIND_CLR);
        req_write = (kind == KIND_WR);
        req_addr  = addr;
        req_wdata = data;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            clear_req = 1'b0;
            return;
        end
        @(posedge clk);
        last_accept = $time;
        exp_err = 1'b0;
        case (kind)
            KIND_RD: begin
                exp_lat   = 2;
                exp_rdata = ref_mem[addr];
            end
            KIND_WR: begin
                ref_mem[addr] = data;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
                exp_lat   = 3;
                readback  = force_en ? force_val : data;
                exp_err   = (readback != data);
                exp_rdata = readback;
`else
                exp_lat   = 1;
                readback  = data;
`endif
            end
            default: begin
                exp_lat = 1;
                for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
                exp_rdata = 16'h0;
            end
        endcase
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        clear_req = 1'b0;
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        ops_done++;
        checkOutput("latency", lat, exp_lat);
        checkOutput("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        checkOutput("ready_with_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint a1;
        int wr_before;
        int rsp_before;
        logic [7:0]  addr;
        logic [15:0] old_val;
        int k;

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 8'h0;
        req_wdata = 16'h0;
        clear_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        #1;
        checkResetValues("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("pre_edge_enable", {31'd0, mem_enable}, 32'd0);
        @(negedge clk);
        checkOutput("first_edge_enable", {31'd0, mem_enable}, 32'd1);
        checkOutput("first_edge_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(KIND_CLR, 8'h00, 16'h0);

        #1 wr_before = wr_pulse_count;
        applyStimulus(KIND_WR, 8'h10, 16'h00A5);
        applyStimulus(KIND_RD, 8'h10, 16'h0);
        #1 checkOutput("wr_pulse_once", wr_pulse_count - wr_before, 32'd1);

        applyStimulus(KIND_WR, 8'hFF, 16'hBEEF);
        applyStimulus(KIND_WR, 8'h00, 16'h1357);
        applyStimulus(KIND_RD, 8'hFF, 16'h0);
        a1 = last_accept;
        applyStimulus(KIND_RD, 8'h00, 16'h0);
        checkOutput("b2b_spacing", 32'((last_accept - a1) / 10), 32'd3);

        // Clear and read requested together: clear first, read stays pending.
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h10;
        @(posedge clk);
        a1 = $time;
        @(negedge clk);
        checkOutput("clr_low", {31'd0, mem_clear}, 32'd0);
        checkOutput("clr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        clear_req = 1'b0;
        @(negedge clk);
        checkOutput("clr_high_again", {31'd0, mem_clear}, 32'd1);
        checkOutput("clr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("clr_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        ops_done++;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        exp_rdata = 16'h0;
        applyStimulus(KIND_RD, 8'h10, 16'h0);
        checkOutput("pending_accept", 32'((last_accept - a1) / 10), 32'd2);

`ifdef MEM_MASTER_WRITE_VERIFY_EN
        force_en  = 1'b1;
        force_val = 16'h1230;
        applyStimulus(KIND_WR, 8'h20, 16'h1234);
        force_en  = 1'b0;
        applyStimulus(KIND_WR, 8'h20, 16'h1234);
`endif

        // Reset while waiting to capture read data.
        applyStimulus(KIND_WR, 8'h33, 16'hC0DE);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h33;
        @(posedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rsp_before = rsp_count;
        rst = 1'b1;
        #1;
        checkResetValues("rst_rdcap");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rdata = 16'h0;
        @(negedge clk);
        checkOutput("rel_enable", {31'd0, mem_enable}, 32'd1);
        checkOutput("rel_ready", {31'd0, req_ready}, 32'd1);
        #1 checkOutput("rst_no_rsp", rsp_count - rsp_before, 32'd0);

        // Reset before the write-commit edge must leave the old contents.
        old_val = ref_mem[8'h33];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h33;
        req_wdata = ~old_val;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("wr_cmd_strobe", {31'd0, mem_write_en}, 32'd1);
        rst = 1'b1;
        #1 checkOutput("rst_wr_strobe", {31'd0, mem_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(KIND_RD, 8'h33, 16'h0);

        // Randomized traffic against the reference memory.
        for (int n = 0; n < 50; n++) begin
            k = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: addr = 8'h00;
                1: addr = 8'hFF;
                default: addr = 8'($urandom_range(0, 255));
            endcase
            if (k < 5) applyStimulus(KIND_RD, addr, 16'h0);
            else if (k < 9) applyStimulus(KIND_WR, addr, 16'($urandom_range(0, 65535)));
            else applyStimulus(KIND_CLR, addr, 16'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        #1;
        checkOutput("strobe_overlap", overlap_count, 32'd0);
        checkOutput("rsp_pulse_count", rsp_count, ops_done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator for the accumulator processor's single-port `RAM`. It accepts one read, write or clear request at a time on a valid/ready request port. It sequences `RAM`'s enable, read, write and clear strobes to match that block's registered read timing, then returns a single-cycle response. The block sits between the control unit (fetch/operand/store path) and `RAM`, and is the only driver of `RAM`'s control inputs.

## Interface
- `A`, 8, address width (matches `RAM` `a`)
- `W`, 16, data width (matches `RAM` `w`)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept; high only in IDLE
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  A  word address
- `req_wdata`  in  W  write data
- `clear_req`  in  1  request a full-memory clear; sampled only in IDLE
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  W  read data; held until the next read or clear
- `rsp_err`  out  1  write-verify mismatch; valid with `rsp_valid`
- `mem_enable`  out  1  to `RAM` `enable`
- `mem_clear`  out  1  to `RAM` `clear` (active-low)
- `mem_read_en`, `mem_write_en`  out  1  to `RAM` `read_en` / `write_en`
- `mem_addr`  out  A  to `RAM` `addr`
- `mem_datain`  out  W  to `RAM` `datain`
- `mem_dataout`  in  W  from `RAM` `dataout`

## Operation
- All outputs are registered.
- **Reset values:**
  - 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_enable`, `mem_read_en`, `mem_write_en`, `mem_addr`, `mem_datain`.
  - 1: `mem_clear`.
  - With `mem_enable` = 0, `RAM` tristates its output during reset.
- **After reset release:**
  - The first edge sets `mem_enable` = 1 and `req_ready` = 1.
  - `mem_enable` then stays 1 until the next reset.
- **States:** IDLE, RD_CMD, RD_CAP, WR_CMD, VFY_CMD, VFY_CAP, CLR.
- **IDLE:**
  - `clear_req` has priority over `req_valid`. When both are present, only the clear is taken and the request stays pending.
  - Accept = `req_valid && req_ready`. `req_addr`/`req_wdata` are latched into `mem_addr`/`mem_datain` on the accept edge.
- **Read path:** IDLE→RD_CMD with `mem_read_en` = 1; RD_CMD→RD_CAP with `mem_read_en` = 0; RD_CAP→IDLE, capturing `mem_dataout` into `rsp_rdata` and pulsing `rsp_valid`.
- **Write path:** IDLE→WR_CMD with `mem_write_en` = 1; WR_CMD→IDLE with `mem_write_en` = 0 and `rsp_valid` pulsed. `rsp_rdata` is unchanged and `rsp_err` = 0.
- **Clear:** IDLE→CLR with `mem_clear` = 0 for exactly one cycle; CLR→IDLE with `rsp_valid` pulsed and `rsp_rdata` = 0.
- **Strobes:** `mem_read_en` and `mem_write_en` are never high together.
- **Addressing:** addresses are used verbatim. 0 and 2^A−1 are legal, with no wrap logic. Data is passed bit-exact, with no width conversion.
- **Reset mid-operation:** return to IDLE immediately and drop all strobes. No `rsp_valid` is issued. A write whose WR_CMD edge has not yet occurred is not committed.

## Timing
- The accept edge is E0.
- **Read:** `RAM` samples at E1, and the block captures at E2. `rsp_valid` is high in the cycle after E2, i.e. 2 cycles after accept.
- **Write:** committed at E1. `rsp_valid` is high in the cycle after E1.
- **Clear:** `RAM` clears at E1. `rsp_valid` is high in the cycle after E1.
- **Overlap:** `req_ready` is high in the same cycle as `rsp_valid`, so a new request can be accepted while the response is shown.
- **Throughput:** one read per 3 cycles; one write per 2 cycles.

## Configuration
- `MEM_MASTER_WRITE_VERIFY_EN` defined:
  - WR_CMD→VFY_CMD (`mem_read_en` = 1, same address)→VFY_CAP→IDLE.
  - At the E3 edge, the read-back is compared with `mem_datain`.
  - `rsp_valid` is pulsed with `rsp_err` = (mismatch), and `rsp_rdata` = the read-back word.
  - Write latency becomes 3 cycles, and throughput becomes one write per 4 cycles.
- Undefined:
  - VFY states are absent.
  - `rsp_err` is tied to 0.

## Test plan
- Write 16'h00A5 to 8'h10, then read 8'h10 → `mem_write_en` pulses once; the read `rsp_valid` arrives 2 cycles after accept with `rsp_rdata` = 16'h00A5.
- Back-to-back reads at 8'hFF then 8'h00, with `req_valid` held high → accepts 3 cycles apart and correct data per address; strobes never overlap.
- `clear_req` and `req_valid` asserted together in IDLE → `mem_clear` low for one cycle, then `rsp_valid` with `rsp_rdata` = 0; the pending read is accepted next and returns 16'h0000.
- With `MEM_MASTER_WRITE_VERIFY_EN`, write 16'h1234 while the bench forces `mem_dataout` = 16'h1230 → `rsp_valid` 3 cycles after accept with `rsp_err` = 1; unforced → `rsp_err` = 0.
- Assert `rst` during RD_CAP → all outputs reach their reset values without waiting for a clock edge, and no `rsp_valid` is seen. The first edge after release sets `mem_enable` = 1 and `req_ready` = 1.
- Assert `rst` while in WR_CMD, before the commit edge → a subsequent read of that address returns the old contents.
